// File: rtl/fifo_arb_nch.sv
// rtl/fifo_arb_nch.sv - N-channel FIFO round-robin arbiter with grant lock
// Optional burst grant enabled by defining FIFO_ARB_BURST_EN.
module fifo_arb_nch #(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  input  logic                       out_ready
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   locked_ch;
  logic [CH_W-1:0]   scan_ch;
  logic [CH_W-1:0]   win;
  logic              any_valid;
  logic              transfer;
  logic              lock;
  state_t            state;
  state_t            state_nxt;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      not_empty[i] = (count[i] != '0);
      in_ready[i]  = (count[i] != CNT_W'(DEPTH));
      push[i]      = in_valid[i] & in_ready[i];
      pop[i]       = transfer & (win == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  // Storage is not reset: emptiness is tracked solely by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    scan_ch   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_valid && not_empty[idx]) begin
        scan_ch   = CH_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    win       = lock ? locked_ch : scan_ch;
    out_valid = any_valid;
    out_ch    = any_valid ? win : '0;
    out_data  = any_valid ? mem[win][rd_ptr[win]] : '0;
    transfer  = any_valid & out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      locked_ch <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && out_valid && !out_ready) locked_ch <= scan_ch;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (out_valid && !out_ready) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lock = (state == HOLD);
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BC_W = $clog2(MAX_BURST) + 1;

  logic [BC_W-1:0] burst_cnt;
  logic [BC_W-1:0] burst_nxt;
  logic            burst_end;

  // rr_ptr parks on the burst owner; a grant to any other channel starts a fresh burst.
  always_comb begin
    burst_nxt = ((win == rr_ptr) ? burst_cnt : '0) + BC_W'(1);
    burst_end = (burst_nxt == BC_W'(MAX_BURST)) ||
                ((count[win] == CNT_W'(1)) && !push[win]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (transfer) begin
      if (burst_end) begin
        rr_ptr    <= next_ch(win);
        burst_cnt <= '0;
      end else begin
        rr_ptr    <= win;
        burst_cnt <= burst_nxt;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= next_ch(win);
    end
  end
`endif

endmodule
